// File: rtl/sprite_vga_if.sv
// Sprite ROM bus: the engine drives a texel address and takes back a 6-bit colour
// that must be valid in the same cycle as that registered address.
interface sprite_vga_if #(
    parameter int unsigned AW = 11
) ();
    logic [AW-1:0] rom_addr;
    logic [5:0]    rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_vga_engine.sv
// VGA timing generator that composites one scaled, animated, bouncing sprite over a
// flat background. Counter value to pins is a fixed two-stage pipeline.
module sprite_vga_engine #(
    parameter int unsigned VGA_WIDTH     = 640,
    parameter int unsigned VGA_HEIGHT    = 480,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC_PULSE  = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC_PULSE  = 2,
    parameter int unsigned V_BACK_PORCH  = 33,
    parameter bit          SYNC_POL      = 1'b1,
    parameter int unsigned SPR_W         = 32,
    parameter int unsigned SPR_H         = 20,
    parameter int unsigned SCALE_LOG2    = 3,
    parameter int unsigned ANIM_FRAMES   = 2,
    parameter int unsigned ANIM_DIV      = 16,
    parameter int unsigned X0            = 188,
    parameter int unsigned Y0            = 160,
    parameter int unsigned DX            = 2,
    parameter int unsigned DY            = 1,
    parameter logic [5:0]  TRANSPARENT   = 6'b111111,
    parameter logic [5:0]  BG_COLOR      = 6'b111000,
    localparam int unsigned AW = $clog2(ANIM_FRAMES * SPR_W * SPR_H),
    localparam int unsigned FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    sprite_vga_if.master  rom,
    output logic [7:0]    vga_pmod,
    output logic          frame_start,
    output logic [FW-1:0] anim_frame
);
    localparam int unsigned H_TOTAL = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int unsigned V_TOTAL = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    // One spare bit keeps pos + extent and the bounce tests free of wrap-around.
    localparam int unsigned PW = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL) + 1;
    localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned SPR_SZ = SPR_W * SPR_H;

    localparam logic [PW-1:0] H_LAST = PW'(H_TOTAL - 1);
    localparam logic [PW-1:0] V_LAST = PW'(V_TOTAL - 1);
    localparam logic [PW-1:0] H_VIS  = PW'(VGA_WIDTH);
    localparam logic [PW-1:0] V_VIS  = PW'(VGA_HEIGHT);
    localparam logic [PW-1:0] HS_ON  = PW'(VGA_WIDTH + H_FRONT_PORCH);
    localparam logic [PW-1:0] HS_OFF = PW'(VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [PW-1:0] VS_ON  = PW'(VGA_HEIGHT + V_FRONT_PORCH);
    localparam logic [PW-1:0] VS_OFF = PW'(VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [PW-1:0] EXT_X  = PW'(SPR_W << SCALE_LOG2);
    localparam logic [PW-1:0] EXT_Y  = PW'(SPR_H << SCALE_LOG2);
    localparam logic [PW-1:0] X_MAX  = PW'(VGA_WIDTH - (SPR_W << SCALE_LOG2));
    localparam logic [PW-1:0] Y_MAX  = PW'(VGA_HEIGHT - (SPR_H << SCALE_LOG2));
    localparam logic [PW-1:0] STEP_X = PW'(DX);
    localparam logic [PW-1:0] STEP_Y = PW'(DY);

    logic [PW-1:0] x_q, x_d, y_q, y_d;
    logic [PW-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [FW-1:0] anim_q, anim_d;
    logic [DW-1:0] div_q, div_d;
    logic          hit_q, hit_d, vis_q, vis_d, hs_q, hs_d, vs_q, vs_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    pmod_q, pmod_d;
    logic          fs_q, fs_d;

    logic          line_end, frame_end, flip_x, flip_y;
    logic [PW-1:0] nx_x, nx_y, off_x, off_y;
    logic [5:0]    colour;

    always_comb begin
        line_end  = (x_q == H_LAST);
        frame_end = line_end && (y_q == V_LAST);
        x_d = line_end ? '0 : x_q + 1'b1;
        y_d = y_q;
        if (line_end) y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;

        nx_x   = dir_x_q ? pos_x_q + STEP_X : pos_x_q - STEP_X;
        nx_y   = dir_y_q ? pos_y_q + STEP_Y : pos_y_q - STEP_Y;
        flip_x = dir_x_q ? (nx_x > X_MAX) : (pos_x_q < STEP_X);
        flip_y = dir_y_q ? (nx_y > Y_MAX) : (pos_y_q < STEP_Y);

        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        anim_d  = anim_q;
        div_d   = div_q;
        if (frame_end && enable) begin
            if (flip_x) dir_x_d = ~dir_x_q;
            else        pos_x_d = nx_x;
            if (flip_y) dir_y_d = ~dir_y_q;
            else        pos_y_d = nx_y;
            if (div_q == DW'(ANIM_DIV - 1)) begin
                div_d  = '0;
                anim_d = (anim_q == FW'(ANIM_FRAMES - 1)) ? '0 : anim_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        // Stage 1: hit test and texel address from the current counters.
        off_x  = x_q - pos_x_q;
        off_y  = y_q - pos_y_q;
        hit_d  = (x_q >= pos_x_q) && (x_q < pos_x_q + EXT_X) &&
                 (y_q >= pos_y_q) && (y_q < pos_y_q + EXT_Y);
        addr_d = hit_d ? AW'(32'(anim_q) * SPR_SZ + 32'(off_y >> SCALE_LOG2) * SPR_W +
                             32'(off_x >> SCALE_LOG2))
                       : addr_q;
        vis_d  = (x_q < H_VIS) && (y_q < V_VIS);
        hs_d   = (x_q >= HS_ON && x_q < HS_OFF) ? SYNC_POL : ~SYNC_POL;
        vs_d   = (y_q >= VS_ON && y_q < VS_OFF) ? SYNC_POL : ~SYNC_POL;
        fs_d   = (x_q == '0) && (y_q == '0);

        // Stage 2: rom_data now belongs to addr_q.
        colour = '0;
        if (vis_q) begin
            colour = (hit_q && rom.rom_data != TRANSPARENT) ? rom.rom_data : BG_COLOR;
        end
        pmod_d = {hs_q, colour[5], colour[3], colour[1], vs_q, colour[4], colour[2], colour[0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            pos_x_q <= PW'(X0);
            pos_y_q <= PW'(Y0);
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            anim_q  <= '0;
            div_q   <= '0;
            hit_q   <= 1'b0;
            vis_q   <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            addr_q  <= '0;
            pmod_q  <= {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};
            fs_q    <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            anim_q  <= anim_d;
            div_q   <= div_d;
            hit_q   <= hit_d;
            vis_q   <= vis_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            addr_q  <= addr_d;
            pmod_q  <= pmod_d;
            fs_q    <= fs_d;
        end
    end

    assign rom.rom_addr = addr_q;
    assign vga_pmod     = pmod_q;
    assign frame_start  = fs_q;
    assign anim_frame   = anim_q;
endmodule

// File: tb/tb_sprite_vga_engine.sv
// Directed bench: a default-parameter engine for line timing and a shrunken engine
// (40x29 total, 8x6 sprite) so that many frames of motion and bounces stay short.
module tb_sprite_vga_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    int unsigned cyc = 0;
    int unsigned rom_mode = 0;
    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] def_pmod, sm_pmod;
    logic       def_fs, sm_fs;
    logic [0:0] def_anim, sm_anim;

    always #5 clk = ~clk;

    sprite_vga_if #(.AW(11)) def_if ();
    sprite_vga_if #(.AW(5))  sm_if ();

    assign def_if.rom_data = 6'b000011;

    always_comb begin
        case (rom_mode)
            0:       sm_if.rom_data = 6'b000011;
            1:       sm_if.rom_data = 6'b111111;
            default: sm_if.rom_data = {1'b1, sm_if.rom_addr};
        endcase
    end

    sprite_vga_engine u_def (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rom         (def_if),
        .vga_pmod    (def_pmod),
        .frame_start (def_fs),
        .anim_frame  (def_anim)
    );

    sprite_vga_engine #(
        .VGA_WIDTH(32), .VGA_HEIGHT(24),
        .H_FRONT_PORCH(2), .H_SYNC_PULSE(4), .H_BACK_PORCH(2),
        .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(2),
        .SYNC_POL(1'b0), .SPR_W(4), .SPR_H(3), .SCALE_LOG2(1),
        .ANIM_FRAMES(2), .ANIM_DIV(4), .X0(22), .Y0(17), .DX(2), .DY(1),
        .TRANSPARENT(6'b111111), .BG_COLOR(6'b001100)
    ) u_sm (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rom         (sm_if),
        .vga_pmod    (sm_pmod),
        .frame_start (sm_fs),
        .anim_frame  (sm_anim)
    );

    // cyc = n after the n-th active edge out of reset; pins then show counter n-2.
    always_ff @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    localparam logic [5:0] DEF_BG = 6'b111000;
    localparam logic [5:0] SM_BG  = 6'b001100;
    localparam logic [5:0] RED    = 6'b000011;

    function automatic logic [5:0] col(input logic [7:0] p);
        return {p[6], p[2], p[5], p[1], p[4], p[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Phase 1: default timing, motion frozen.
        at(1);    check("def_fs_first", def_fs, 1);  check("sm_fs_first", sm_fs, 1);
        at(2);    check("def_fs_drop", def_fs, 0);
        at(35);   check("sm_hs_before", sm_pmod[7], 1);
        at(36);   check("sm_hs_on", sm_pmod[7], 0);
        at(641);  check("def_x639_bg", col(def_pmod), DEF_BG);
        at(642);  check("def_x640_blank", col(def_pmod), 0);
        at(657);  check("def_hs_x655", def_pmod[7], 0);
        at(658);  check("def_hs_x656", def_pmod[7], 1);  check("def_vs_line0", def_pmod[3], 0);
        at(753);  check("def_hs_x751", def_pmod[7], 1);
        at(754);  check("def_hs_x752", def_pmod[7], 0);
        at(801);  check("def_fs_line1", def_fs, 0);
        at(1458); check("def_hs_line1", def_pmod[7], 1);
        at(1500); check("def_hs_midline", def_pmod[7], 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("def_rst_pmod", def_pmod, 8'h00);
        check("sm_rst_pmod", sm_pmod, 8'h88);
        check("sm_rst_addr", sm_if.rom_addr, 0);
        check("sm_rst_fs", sm_fs, 0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        rst_n  = 1'b1;

        // Phase 2: small engine, sprite moving from (22,17), bouncing after frame 1.
        at(1);    check("sm_fs", sm_fs, 1);
        at(2);    check("sm_fs_drop", sm_fs, 0);
        at(703);  check("f0_left_of_spr", col(sm_pmod), SM_BG);
        at(704);  check("f0_spr_origin", col(sm_pmod), RED);
        at(714);  check("f0_x32_blank", col(sm_pmod), 0);
        at(828);  check("f0_addr_27_20", sm_if.rom_addr, 6);
        at(911);  check("f0_spr_last", col(sm_pmod), RED);
        at(912);  check("f0_right_of_spr", col(sm_pmod), SM_BG);
        at(951);  check("f0_below_spr", col(sm_pmod), SM_BG);
        at(1001); check("f0_vs_y24", sm_pmod[3], 1);
        at(1002); check("f0_vs_y25", sm_pmod[3], 0);
        at(1864); check("f1_old_origin", col(sm_pmod), SM_BG);
        at(1905); check("f1_left", col(sm_pmod), SM_BG);
        at(1906); check("f1_origin_24_18", col(sm_pmod), RED);
        at(3026); check("f2_above_held", col(sm_pmod), SM_BG);
        at(3065); check("f2_left_held", col(sm_pmod), SM_BG);
        at(3066); check("f2_origin_held", col(sm_pmod), RED);
        at(4183); check("f3_left", col(sm_pmod), SM_BG);
        at(4184); check("f3_origin_22_17", col(sm_pmod), RED);
        rom_mode = 2;
        at(4639); check("f3_anim", sm_anim, 0);
        at(4640); check("f4_anim", sm_anim, 1);
        at(5301); check("f4_addr_origin", sm_if.rom_addr, 12);
        at(5302); check("f4_origin_col", col(sm_pmod), 6'd44);
        at(5509); check("f4_last_texel", col(sm_pmod), 6'd55);
        rom_mode = 1;
        at(5802); check("f5_x0y0_bg", col(sm_pmod), SM_BG);
        at(6419); check("f5_addr_origin", sm_if.rom_addr, 12);
        at(6420); check("f5_transparent", col(sm_pmod), SM_BG);
        at(6500);
        enable   = 1'b0;
        rom_mode = 2;

        // Twenty frozen frames: timing runs, pos (18,15) and anim 1 stay put.
        at(29001); check("f25_fs", sm_fs, 1);
        at(29035); check("f25_hs_before", sm_pmod[7], 1);
        at(29036); check("f25_hs_on", sm_pmod[7], 0);
        at(29619); check("f25_left", col(sm_pmod), SM_BG);
        at(29620); check("f25_origin", col(sm_pmod), 6'd44);  check("f25_anim", sm_anim, 1);
        at(29700);
        enable = 1'b1;
        at(30737); check("f26_left", col(sm_pmod), SM_BG);
        at(30738); check("f26_origin_16_14", col(sm_pmod), 6'd44);

        at(30740);
        rst_n = 1'b0;
        @(negedge clk);
        check("sm_rst2_pmod", sm_pmod, 8'h88);
        check("sm_rst2_addr", sm_if.rom_addr, 0);
        check("sm_rst2_anim", sm_anim, 0);
        check("sm_rst2_fs", sm_fs, 0);
        check("def_rst2_pmod", def_pmod, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
